// File: rtl/kpn_queue_reader.sv
// Consumer-side reader for the KPN token queue: pops tokens into a 2-entry
// output buffer and forwards them over a valid/ready stream, in bursts or continuously.
module kpn_queue_reader #(
  parameter int unsigned BITS_NUMBER = 16,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   q_empty,
  input  logic [BITS_NUMBER-1:0] q_data,
  output logic                   q_rd,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   burst_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   tokens_read
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   cont_q, cont_d;
  logic [CNT_WIDTH-1:0]   tokens_q;
  logic [1:0]             occ_q, occ_d;
  logic [BITS_NUMBER-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                   space, pop;

  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = buf0_q;
  assign pop         = out_valid & out_ready;
  // A full buffer still has room when its head leaves in the same cycle.
  assign space       = (occ_q < 2'd2) | ((occ_q == 2'd2) & pop);
  assign q_rd        = (state_q == StRead) & ~q_empty & (cont_q | (remaining_q != '0)) & space;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign tokens_read = tokens_q;

  // buf0 is the head; buf1 only holds data when occ==2.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({q_rd, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = q_data;
        else               buf1_d = q_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = q_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = q_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cont_d      = cont_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = burst_len;
          cont_d      = (burst_len == '0);
          state_d     = StRead;
        end
      end
      StRead: begin
        if (q_rd && !cont_q) remaining_d = remaining_q - LEN_WIDTH'(1);
        if (cont_q) begin
          if (stop) state_d = StDrain;
        end else if (q_rd && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (occ_q == 2'd0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cont_q      <= 1'b0;
      tokens_q    <= '0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cont_q      <= cont_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      if (q_rd) tokens_q <= tokens_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_kpn_queue_reader.sv
// Directed bench for kpn_queue_reader: a software queue feeds the DUT and a
// scoreboard tracks token order, buffer occupancy and pop legality every cycle.
module tb_kpn_queue_reader;
  localparam int unsigned BN = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          q_empty = 1'b1;
  logic [BN-1:0] q_data = '0;
  logic          q_rd;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BN-1:0] out_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] tokens_read;

  kpn_queue_reader #(.BITS_NUMBER(BN), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q_empty(q_empty), .q_data(q_data), .q_rd(q_rd),
    .start(start), .stop(stop), .burst_len(burst_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
    .tokens_read(tokens_read)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [BN-1:0] src[$];   // upstream queue contents
  logic [BN-1:0] expq[$];  // tokens popped and not yet delivered
  logic [BN-1:0] got[$];   // tokens delivered downstream in this test
  int  occ_m = 0;
  int  pop_cnt = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  first_pop = -1;
  int  last_pop = -1;
  bit  do_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream queue model: head and empty flag follow src, popped after each q_rd edge.
  always @(posedge clk) begin
    #2;
    if (do_pop) begin
      if (src.size() > 0) src.delete(0);
      do_pop = 0;
    end
    q_empty = (src.size() == 0);
    q_data  = (src.size() > 0) ? src[0] : '0;
  end

  always @(negedge rst_n) begin
    expq.delete();
    occ_m = 0;
  end

  // Per-cycle scoreboard, sampled mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk("out_valid_vs_occ", {31'd0, out_valid}, {31'd0, occ_m != 0});
      if (q_rd) begin
        chk("q_rd_while_empty", {31'd0, q_empty}, 32'd0);
        chk("q_rd_while_idle", {31'd0, busy}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("out_underflow", 32'd1, 32'd0);
        end else begin
          chk("out_data_order", {16'd0, out_data}, {16'd0, expq[0]});
          expq.delete(0);
        end
        got.push_back(out_data);
        occ_m--;
      end
      if (q_rd) begin
        expq.push_back(q_data);
        occ_m++;
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        do_pop = 1;
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_test();
    got.delete();
    pop_cnt   = 0;
    done_cnt  = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic fill(input logic [BN-1:0] base, input int n);
    for (int i = 0; i < n; i++) src.push_back(base + BN'(i));
  endtask

  task automatic kick(input logic [LW-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    if (done_cnt == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    tick();
    chk({name, "_done_once"}, done_cnt, 32'd1);
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_got(input string name, input logic [BN-1:0] base, input int n);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({name, "_tok"}, {16'd0, got[i]}, {16'd0, base + BN'(i)});
  endtask

  initial begin
    #12;
    chk("rst_q_rd", {31'd0, q_rd}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tokens", {16'd0, tokens_read}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Burst of 4 at full rate.
    new_test();
    fill(16'h0001, 4);
    tick();
    kick(8'd4);
    wait_done("t1");
    chk("t1_pops", pop_cnt, 32'd4);
    chk("t1_consecutive", last_pop - first_pop, 32'd3);
    chk_got("t1", 16'h0001, 4);
    chk("t1_tokens", {16'd0, tokens_read}, 32'd4);

    // Burst shorter than the queue contents.
    new_test();
    fill(16'h0010, 5);
    tick();
    kick(8'd3);
    wait_done("t2");
    chk("t2_pops", pop_cnt, 32'd3);
    chk("t2_left", src.size(), 32'd2);
    chk_got("t2", 16'h0010, 3);
    chk("t2_tokens", {16'd0, tokens_read}, 32'd7);
    src.delete();
    tick();

    // Backpressure fills the buffer and stalls the pops.
    new_test();
    fill(16'h0001, 6);
    out_ready = 1'b0;
    tick();
    kick(8'd6);
    for (int i = 0; i < 6; i++) tick();
    chk("t3_stalled_pops", pop_cnt, 32'd2);
    chk("t3_q_rd_low", {31'd0, q_rd}, 32'd0);
    chk("t3_head", {16'd0, out_data}, 32'h0001);
    out_ready = 1'b1;
    wait_done("t3");
    chk("t3_pops", pop_cnt, 32'd6);
    chk_got("t3", 16'h0001, 6);
    chk("t3_tokens", {16'd0, tokens_read}, 32'd13);

    // Blocking read on an empty queue.
    new_test();
    kick(8'd4);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_no_pops_empty", pop_cnt, 32'd0);
    chk("t4_busy_waiting", {31'd0, busy}, 32'd1);
    src.push_back(16'hAAAA);
    src.push_back(16'hBBBB);
    src.push_back(16'hCCCC);
    src.push_back(16'hDDDD);
    wait_done("t4");
    chk("t4_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      chk("t4_tok0", {16'd0, got[0]}, 32'hAAAA);
      chk("t4_tok1", {16'd0, got[1]}, 32'hBBBB);
      chk("t4_tok2", {16'd0, got[2]}, 32'hCCCC);
      chk("t4_tok3", {16'd0, got[3]}, 32'hDDDD);
    end
    chk("t4_tokens", {16'd0, tokens_read}, 32'd17);

    // Continuous mode, stop during the fifth READ cycle.
    new_test();
    fill(16'h0100, 10);
    tick();
    kick(8'd0);
    for (int i = 0; i < 4; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t5");
    chk("t5_pops", pop_cnt, 32'd5);
    chk("t5_left", src.size(), 32'd5);
    chk_got("t5", 16'h0100, 5);
    chk("t5_tokens", {16'd0, tokens_read}, 32'd22);
    src.delete();
    tick();

    // Reset while the buffer is full, then a clean 2-token burst.
    new_test();
    fill(16'h0021, 6);
    out_ready = 1'b0;
    tick();
    kick(8'd6);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_pre_pops", pop_cnt, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_q_rd", {31'd0, q_rd}, 32'd0);
    chk("t6_rst_tokens", {16'd0, tokens_read}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    src.delete();
    new_test();
    out_ready = 1'b1;
    src.push_back(16'h0031);
    src.push_back(16'h0032);
    tick();
    kick(8'd2);
    wait_done("t6");
    chk("t6_pops", pop_cnt, 32'd2);
    chk_got("t6", 16'h0031, 2);
    chk("t6_tokens", {16'd0, tokens_read}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
